// File: rtl/debug_pkg.sv
// Shared encodings for the CPU run-control/debug logic: FSM states, mode select
// values and a small helper for classifying the free-running modes.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_TICK   = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_FAST   = 2'd3
  } mode_t;

  function automatic logic is_free_run(input logic [1:0] mode);
    return (mode == MODE_TICK) || (mode == MODE_FAST);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// One-cycle rising-edge detector for an already-debounced level input.
module edge_pulse (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clock) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/run_control.sv
// Run-control unit: turns step button, slow tick and mode switches into
// single-cycle CPU enable pulses, with breakpoint halt and a step counter.
module run_control
  import debug_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PC_W    = 32,
  parameter int BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               step_btn,
  input  logic               tick,
  input  logic [1:0]         mode,
  input  logic               run_en,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               bkpt_en,
  input  logic [PC_W-1:0]    bkpt_addr,
  input  logic [PC_W-1:0]    pc,
  output logic               cpu_en,
  output logic               cpu_reset,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               halted,
  output logic [1:0]         state
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             state_reg;
  logic               cpu_en_reg;
  logic               cpu_reset_reg;
  logic               halted_reg;
  logic [CNT_W-1:0]   cycle_count_reg;
  logic [BURST_W-1:0] remaining_reg;
  logic               step_edge;
  logic               bp;

  edge_pulse u_step_edge (
    .clock (clock),
    .reset (reset),
    .level (step_btn),
    .pulse (step_edge)
  );

  assign bp = bkpt_en && (pc == bkpt_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cpu_en_reg      <= 1'b0;
      cpu_reset_reg   <= 1'b1;
      halted_reg      <= 1'b0;
      cycle_count_reg <= '0;
      remaining_reg   <= '0;
    end else begin
      cpu_en_reg <= 1'b0;
      // The CPU has now seen reset on one enabled edge.
      if (cpu_en_reg) cpu_reset_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (mode == MODE_MANUAL) begin
            if (step_edge) begin
              cpu_en_reg      <= 1'b1;
              cycle_count_reg <= cycle_count_reg + CNT_ONE;
            end
          end else if (mode == MODE_BURST) begin
            if (step_edge && (burst_len != '0)) begin
              state_reg     <= ST_BURST;
              remaining_reg <= burst_len;
            end
          end else if (run_en) begin
            state_reg <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!run_en || !is_free_run(mode)) begin
            state_reg <= ST_IDLE;
          end else if ((mode == MODE_FAST) || tick) begin
            if (bp) begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end else begin
              cpu_en_reg      <= 1'b1;
              cycle_count_reg <= cycle_count_reg + CNT_ONE;
            end
          end
        end

        ST_BURST: begin
          // A step press aborts the burst even if a tick lands in the same cycle.
          if ((mode != MODE_BURST) || step_edge) begin
            state_reg <= ST_IDLE;
          end else if (tick) begin
            if (bp) begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end else begin
              cpu_en_reg      <= 1'b1;
              cycle_count_reg <= cycle_count_reg + CNT_ONE;
              remaining_reg   <= remaining_reg - BURST_ONE;
              if (remaining_reg == BURST_ONE) state_reg <= ST_IDLE;
            end
          end
        end

        ST_HALT: begin
          if (step_edge) begin
            cpu_en_reg      <= 1'b1;
            cycle_count_reg <= cycle_count_reg + CNT_ONE;
            state_reg       <= ST_IDLE;
            halted_reg      <= 1'b0;
          end else if (!bkpt_en) begin
            state_reg  <= ST_IDLE;
            halted_reg <= 1'b0;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cpu_en      = cpu_en_reg;
  assign cpu_reset   = cpu_reset_reg;
  assign cycle_count = cycle_count_reg;
  assign halted      = halted_reg;
  assign state       = state_reg;

endmodule
